control_unit: RTL and testbench

- Control-unit (device) end of the S/360 parallel channel bus-and-tag interface; the responder to `channel`.
- Recognises its own device address during initial selection and accepts the command byte.
- Presents initial and ending status.
- Moves data bytes with service-in/service-out:
  - write/control commands: channel to device-side AXI-Stream;
  - read commands: device-side AXI-Stream to channel.
- Sits on the device side of the `a_*` tags, one instance per device address.

---
 rtl/channel_pkg.sv | 40 ++++
 rtl/control_unit_select.sv | 27 ++
 rtl/control_unit.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// Shared definitions for both ends of the S/360 bus-and-tag interface:
// control-unit state encoding, status and command bytes, command decode helper.
package channel_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    // Status byte bits (bus bit n == IBM bit n)
    localparam byte_t ST_ATTN = 8'h01;
    localparam byte_t ST_BUSY = 8'h08;
    localparam byte_t ST_CE   = 8'h10;
    localparam byte_t ST_DE   = 8'h20;
    localparam byte_t ST_UC   = 8'h40;
    localparam byte_t ST_UE   = 8'h80;

    localparam byte_t CMD_TEST_IO = 8'h00;

    // Control-unit sequencing states
    typedef enum logic [3:0] {
        CU_IDLE     = 4'd0,
        CU_OP_IN    = 4'd1,
        CU_ADDR_IN  = 4'd2,
        CU_CMD      = 4'd3,
        CU_STAT_IN  = 4'd4,
        CU_STAT_ACK = 4'd5,
        CU_XFER     = 4'd6,
        CU_SVC      = 4'd7,
        CU_SVC_ACK  = 4'd8,
        CU_STOP     = 4'd9,
        CU_END      = 4'd10,
        CU_END_ACK  = 4'd11
    } cu_state_e;

    // Write and control commands have the low command bit set
    function automatic logic is_write(input byte_t cmd);
        return (cmd & 8'h01) != 8'h00;
    endfunction

endpackage

// File: rtl/control_unit_select.sv
// Address match and select-in propagation for an idle control unit.
//   address_out_i/select_out_i/hold_out_i/bus_out_i : channel outbound tags and bus
//   status_pending_i : unit already has status to present; blocks selection
//   match_c          : this unit is being selected
//   select_pass_c    : value select_in should take while idle (pass select down the chain)
module control_unit_select
    import channel_pkg::*;
#(
    parameter byte_t ADDRESS = 8'h10
) (
    input  logic  address_out_i,
    input  logic  select_out_i,
    input  logic  hold_out_i,
    input  byte_t bus_out_i,
    input  logic  status_pending_i,
    output logic  match_c,
    output logic  select_pass_c
);

    logic sel_or_hold;

    assign sel_or_hold   = select_out_i | hold_out_i;
    assign match_c       = address_out_i & sel_or_hold & (bus_out_i == ADDRESS) & ~status_pending_i;
    // Not ours: the select tag ripples on to the next unit
    assign select_pass_c = sel_or_hold & ~match_c & select_out_i;

endmodule

// File: rtl/control_unit.sv
// Device end of the S/360 bus-and-tag channel interface, one per device address.
// Handles initial selection, command/status exchange and byte transfers:
// write/control commands push channel bytes onto data_recv_*, read commands pull
// bytes from data_send_* onto the channel.
//   clk, reset_n               : clock, async active-low reset
//   a_bus_out, a_*_out         : channel outbound bus and tags (suppress ignored)
//   a_bus_in, a_*_in           : inbound bus and tags (request_in tied low)
//   command, active            : latched command byte, unit busy with an operation
//   device_busy, end_transfer  : device busy at command time; end a write transfer
//   data_recv_*                : AXI-Stream of bytes written by the channel
//   data_send_*                : AXI-Stream of bytes read by the channel
module control_unit
    import channel_pkg::*;
#(
    parameter logic [7:0] ADDRESS = 8'h10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] a_bus_out,
    output logic [7:0] a_bus_in,
    input  logic       a_operational_out,
    input  logic       a_address_out,
    input  logic       a_hold_out,
    input  logic       a_select_out,
    input  logic       a_command_out,
    input  logic       a_service_out,
    input  logic       a_suppress_out,
    output logic       a_operational_in,
    output logic       a_address_in,
    output logic       a_select_in,
    output logic       a_status_in,
    output logic       a_service_in,
    output logic       a_request_in,
    output logic [7:0] command,
    output logic       active,
    input  logic       device_busy,
    input  logic       end_transfer,
    output logic [7:0] data_recv_tdata,
    output logic       data_recv_tvalid,
    input  logic       data_recv_tready,
    input  logic [7:0] data_send_tdata,
    input  logic       data_send_tvalid,
    input  logic       data_send_tlast,
    output logic       data_send_tready
);

    localparam byte_t END_STATUS = ST_CE | ST_DE;

    cu_state_e state_q, state_d;
    byte_t     bus_in_q, bus_in_d;
    byte_t     command_q, command_d;
    byte_t     status_q, status_d;
    byte_t     recv_tdata_q, recv_tdata_d;
    logic      op_in_q, op_in_d;
    logic      addr_in_q, addr_in_d;
    logic      sel_in_q, sel_in_d;
    logic      stat_in_q, stat_in_d;
    logic      svc_in_q, svc_in_d;
    logic      recv_tvalid_q, recv_tvalid_d;
    logic      send_tready_q, send_tready_d;
    logic      last_q, last_d;
    logic      end_q, end_d;
    logic      active_q;
    logic      match;
    logic      select_pass;
    logic      unused_suppress;

    assign unused_suppress = a_suppress_out;

    control_unit_select #(
        .ADDRESS (ADDRESS)
    ) u_select (
        .address_out_i    (a_address_out),
        .select_out_i     (a_select_out),
        .hold_out_i       (a_hold_out),
        .bus_out_i        (a_bus_out),
        .status_pending_i (stat_in_q),
        .match_c          (match),
        .select_pass_c    (select_pass)
    );

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= CU_IDLE;
            bus_in_q      <= '0;
            command_q     <= '0;
            status_q      <= '0;
            recv_tdata_q  <= '0;
            op_in_q       <= 1'b0;
            addr_in_q     <= 1'b0;
            sel_in_q      <= 1'b0;
            stat_in_q     <= 1'b0;
            svc_in_q      <= 1'b0;
            recv_tvalid_q <= 1'b0;
            send_tready_q <= 1'b0;
            last_q        <= 1'b0;
            end_q         <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_in_q      <= bus_in_d;
            command_q     <= command_d;
            status_q      <= status_d;
            recv_tdata_q  <= recv_tdata_d;
            op_in_q       <= op_in_d;
            addr_in_q     <= addr_in_d;
            sel_in_q      <= sel_in_d;
            stat_in_q     <= stat_in_d;
            svc_in_q      <= svc_in_d;
            recv_tvalid_q <= recv_tvalid_d;
            send_tready_q <= send_tready_d;
            last_q        <= last_d;
            end_q         <= end_d;
            active_q      <= (state_d != CU_IDLE);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        bus_in_d      = bus_in_q;
        command_d     = command_q;
        status_d      = status_q;
        recv_tdata_d  = recv_tdata_q;
        op_in_d       = op_in_q;
        addr_in_d     = addr_in_q;
        sel_in_d      = sel_in_q;
        stat_in_d     = stat_in_q;
        svc_in_d      = svc_in_q;
        recv_tvalid_d = recv_tvalid_q & ~data_recv_tready;
        send_tready_d = 1'b0;
        last_d        = last_q;
        // end_transfer is a pulse; remember it until the operation finishes
        end_d         = end_q | (end_transfer & (state_q != CU_IDLE));

        if (!a_operational_out) begin
            // Selective reset: abandon the operation, all tags low
            state_d   = CU_IDLE;
            bus_in_d  = '0;
            op_in_d   = 1'b0;
            addr_in_d = 1'b0;
            sel_in_d  = 1'b0;
            stat_in_d = 1'b0;
            svc_in_d  = 1'b0;
            end_d     = 1'b0;
        end else begin
            unique case (state_q)
                CU_IDLE: begin
                    end_d    = 1'b0;
                    last_d   = 1'b0;
                    sel_in_d = select_pass;
                    if (match) begin
                        state_d  = CU_OP_IN;
                        op_in_d  = 1'b1;
                        sel_in_d = 1'b0;
                    end
                end
                CU_OP_IN: begin
                    if (!a_address_out) begin
                        state_d   = CU_ADDR_IN;
                        bus_in_d  = ADDRESS;
                        addr_in_d = 1'b1;
                    end
                end
                CU_ADDR_IN: begin
                    if (a_command_out) begin
                        state_d   = CU_CMD;
                        command_d = a_bus_out;
                        addr_in_d = 1'b0;
                        bus_in_d  = '0;
                        status_d  = device_busy ? ST_BUSY : 8'h00;
                    end
                end
                CU_CMD: begin
                    if (!a_command_out) begin
                        state_d   = CU_STAT_IN;
                        bus_in_d  = status_q;
                        stat_in_d = 1'b1;
                    end
                end
                CU_STAT_IN: begin
                    if (a_service_out) begin
                        state_d   = CU_STAT_ACK;
                        stat_in_d = 1'b0;
                        bus_in_d  = '0;
                    end
                end
                CU_STAT_ACK: begin
                    if (!a_service_out) begin
                        // Test I/O or any non-zero initial status ends the operation here
                        if ((command_q == CMD_TEST_IO) || (status_q != 8'h00)) begin
                            state_d = CU_IDLE;
                            op_in_d = 1'b0;
                        end else begin
                            state_d = CU_XFER;
                        end
                    end
                end
                CU_XFER: begin
                    if (is_write(command_q)) begin
                        if (end_q) begin
                            state_d   = CU_END;
                            bus_in_d  = END_STATUS;
                            stat_in_d = 1'b1;
                        end else if (!recv_tvalid_q) begin
                            // Only request a byte once the previous one has drained
                            state_d  = CU_SVC;
                            svc_in_d = 1'b1;
                        end
                    end else if (data_send_tvalid) begin
                        state_d       = CU_SVC;
                        send_tready_d = 1'b1;
                        bus_in_d      = data_send_tdata;
                        svc_in_d      = 1'b1;
                        last_d        = data_send_tlast;
                    end
                end
                CU_SVC: begin
                    // Channel stop (command_out) takes priority over service_out
                    if (a_command_out) begin
                        state_d  = CU_STOP;
                        svc_in_d = 1'b0;
                        bus_in_d = '0;
                    end else if (a_service_out) begin
                        state_d  = CU_SVC_ACK;
                        svc_in_d = 1'b0;
                        bus_in_d = '0;
                        if (is_write(command_q)) begin
                            recv_tdata_d  = a_bus_out;
                            recv_tvalid_d = 1'b1;
                        end
                    end
                end
                CU_SVC_ACK: begin
                    if (!a_service_out) begin
                        if (last_q || end_q) begin
                            state_d   = CU_END;
                            bus_in_d  = END_STATUS;
                            stat_in_d = 1'b1;
                        end else begin
                            state_d = CU_XFER;
                        end
                    end
                end
                CU_STOP: begin
                    if (!a_command_out) begin
                        state_d   = CU_END;
                        bus_in_d  = END_STATUS;
                        stat_in_d = 1'b1;
                    end
                end
                CU_END: begin
                    if (a_service_out) begin
                        state_d   = CU_END_ACK;
                        stat_in_d = 1'b0;
                        bus_in_d  = '0;
                    end
                end
                CU_END_ACK: begin
                    if (!a_service_out) begin
                        state_d = CU_IDLE;
                        op_in_d = 1'b0;
                    end
                end
                default: begin
                    state_d = CU_IDLE;
                end
            endcase
        end
    end

    assign a_bus_in         = bus_in_q;
    assign a_operational_in = op_in_q;
    assign a_address_in     = addr_in_q;
    assign a_select_in      = sel_in_q;
    assign a_status_in      = stat_in_q;
    assign a_service_in     = svc_in_q;
    assign a_request_in     = 1'b0;
    assign command          = command_q;
    assign active           = active_q;
    assign data_recv_tdata  = recv_tdata_q;
    assign data_recv_tvalid = recv_tvalid_q;
    assign data_send_tready = send_tready_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: plays the channel side of bus-and-tag, with an
// AXI-Stream sink (with stall) and source on the device side.
module tb_control_unit;

    localparam logic [7:0] ADDR  = 8'h10;
    localparam int         STALL = 5;
    localparam int SIG_OP = 0, SIG_ADDR = 1, SIG_SEL = 2, SIG_STAT = 3, SIG_SVC = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] a_bus_out;
    logic [7:0] a_bus_in;
    logic       a_operational_out, a_address_out, a_hold_out, a_select_out;
    logic       a_command_out, a_service_out, a_suppress_out;
    logic       a_operational_in, a_address_in, a_select_in, a_status_in;
    logic       a_service_in, a_request_in;
    logic [7:0] command;
    logic       active;
    logic       device_busy, end_transfer;
    logic [7:0] data_recv_tdata;
    logic       data_recv_tvalid, data_recv_tready;
    logic [7:0] data_send_tdata;
    logic       data_send_tvalid, data_send_tlast, data_send_tready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] recv_q[$];
    logic [8:0] send_q[$];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] cmd;
        logic       busy;
        int         nbytes;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_sel;
        logic [7:0] exp_init;
        logic [7:0] exp_end;
    } vec_t;

    vec_t vecs[7];

    control_unit #(.ADDRESS(ADDR)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .a_bus_out         (a_bus_out),
        .a_bus_in          (a_bus_in),
        .a_operational_out (a_operational_out),
        .a_address_out     (a_address_out),
        .a_hold_out        (a_hold_out),
        .a_select_out      (a_select_out),
        .a_command_out     (a_command_out),
        .a_service_out     (a_service_out),
        .a_suppress_out    (a_suppress_out),
        .a_operational_in  (a_operational_in),
        .a_address_in      (a_address_in),
        .a_select_in       (a_select_in),
        .a_status_in       (a_status_in),
        .a_service_in      (a_service_in),
        .a_request_in      (a_request_in),
        .command           (command),
        .active            (active),
        .device_busy       (device_busy),
        .end_transfer      (end_transfer),
        .data_recv_tdata   (data_recv_tdata),
        .data_recv_tvalid  (data_recv_tvalid),
        .data_recv_tready  (data_recv_tready),
        .data_send_tdata   (data_send_tdata),
        .data_send_tvalid  (data_send_tvalid),
        .data_send_tlast   (data_send_tlast),
        .data_send_tready  (data_send_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            SIG_OP:   return a_operational_in;
            SIG_ADDR: return a_address_in;
            SIG_SEL:  return a_select_in;
            SIG_STAT: return a_status_in;
            SIG_SVC:  return a_service_in;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic val, input string nm);
        int i = 0;
        while (get_sig(sel) !== val && i < 100) begin
            tick();
            i++;
        end
        if (get_sig(sel) !== val) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout, tag is %b wanted %b", nm, get_sig(sel), val);
        end
    endtask

    // Recv sink: stalls tready for STALL cycles on every byte
    initial begin : sink
        data_recv_tready = 1'b0;
        forever begin
            tick();
            if (data_recv_tvalid && !data_recv_tready) begin
                repeat (STALL) tick();
                if (data_recv_tvalid) begin
                    data_recv_tready = 1'b1;
                    recv_q.push_back(data_recv_tdata);
                    tick();
                    data_recv_tready = 1'b0;
                end
            end
        end
    end

    // Send source: presents send_q head, pops on handshake
    initial begin : source
        data_send_tvalid = 1'b0;
        data_send_tdata  = 8'h00;
        data_send_tlast  = 1'b0;
        forever begin
            tick();
            if (data_send_tvalid && data_send_tready) begin
                tick();
                if (send_q.size() > 0) send_q.delete(0);
            end
            data_send_tvalid = (send_q.size() > 0);
            data_send_tdata  = (send_q.size() > 0) ? send_q[0][7:0] : 8'h00;
            data_send_tlast  = (send_q.size() > 0) ? send_q[0][8] : 1'b0;
        end
    end

    // Channel initial selection up to acceptance of initial status
    task automatic select_unit(input logic [7:0] addr, input logic [7:0] cmd, input logic busy,
                               output bit sel, output logic [7:0] st);
        st = 8'h00;
        device_busy   = busy;
        a_bus_out     = addr;
        a_address_out = 1'b1;
        tick();
        a_select_out = 1'b1;
        a_hold_out   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_operational_in || a_select_in) break;
        end
        sel = a_operational_in;
        if (!sel) return;
        check("sel_in_low_when_ours", a_select_in, 8'h00);
        a_address_out = 1'b0;
        wait_sig(SIG_ADDR, 1'b1, "address_in_rise");
        check("address_echo", a_bus_in, addr);
        a_bus_out     = cmd;
        a_command_out = 1'b1;
        wait_sig(SIG_ADDR, 1'b0, "address_in_drop");
        a_command_out = 1'b0;
        a_bus_out     = 8'h00;
        device_busy   = 1'b0;
        check("command_latch", command, cmd);
        wait_sig(SIG_STAT, 1'b1, "init_status_in");
        st = a_bus_in;
        a_service_out = 1'b1;
        wait_sig(SIG_STAT, 1'b0, "init_status_ack");
        a_service_out = 1'b0;
    endtask

    task automatic release_channel();
        a_address_out = 1'b0;
        a_select_out  = 1'b0;
        a_hold_out    = 1'b0;
        a_command_out = 1'b0;
        a_service_out = 1'b0;
        a_bus_out     = 8'h00;
        tick();
        tick();
    endtask

    // One full operation driven from a vector record
    task automatic run_vec(input vec_t v, input int idx);
        bit         sel;
        bit         done;
        logic [7:0] st;
        logic [7:0] data[2];
        int         nrx;
        bit         wr;
        data[0] = v.d0;
        data[1] = v.d1;
        wr  = v.cmd[0];
        nrx = 0;
        recv_q.delete();
        if (!wr) begin
            for (int i = 0; i < v.nbytes; i++)
                send_q.push_back({(i == v.nbytes - 1), data[i]});
        end
        select_unit(v.addr, v.cmd, v.busy, sel, st);
        check($sformatf("v%0d_selected", idx), 8'(sel), 8'(v.exp_sel));
        if (!sel) begin
            check($sformatf("v%0d_select_pass", idx), 8'(a_select_in), 8'h01);
            check($sformatf("v%0d_op_in_idle", idx), 8'(a_operational_in), 8'h00);
            release_channel();
            check($sformatf("v%0d_select_drop", idx), 8'(a_select_in), 8'h00);
            return;
        end
        check($sformatf("v%0d_init_status", idx), st, v.exp_init);
        if (st == 8'h00 && v.cmd != 8'h00) begin
            done = 1'b0;
            for (int t = 0; t < 300 && !done; t++) begin
                if (a_status_in) begin
                    check($sformatf("v%0d_end_status", idx), a_bus_in, v.exp_end);
                    a_service_out = 1'b1;
                    wait_sig(SIG_STAT, 1'b0, "end_status_ack");
                    a_service_out = 1'b0;
                    done = 1'b1;
                end else if (a_service_in && nrx < 2) begin
                    if (wr) begin
                        a_bus_out     = data[nrx];
                        a_service_out = 1'b1;
                        wait_sig(SIG_SVC, 1'b0, "write_svc_drop");
                        if (nrx == v.nbytes - 1) end_transfer = 1'b1;
                        a_service_out = 1'b0;
                        tick();
                        end_transfer = 1'b0;
                    end else begin
                        check($sformatf("v%0d_read_b%0d", idx, nrx), a_bus_in, data[nrx]);
                        a_service_out = 1'b1;
                        wait_sig(SIG_SVC, 1'b0, "read_svc_drop");
                        a_service_out = 1'b0;
                    end
                    nrx++;
                end else begin
                    tick();
                end
            end
            if (!done) check($sformatf("v%0d_end_timeout", idx), 8'h00, 8'h01);
            check($sformatf("v%0d_byte_count", idx), 8'(nrx), 8'(v.nbytes));
        end
        wait_sig(SIG_OP, 1'b0, "op_in_drop");
        check($sformatf("v%0d_active_clear", idx), 8'(active), 8'h00);
        if (wr && v.nbytes > 0) begin
            for (int t = 0; t < 50 && recv_q.size() < v.nbytes; t++) tick();
            check($sformatf("v%0d_recv_count", idx), 8'(recv_q.size()), 8'(v.nbytes));
            for (int i = 0; i < v.nbytes && i < recv_q.size(); i++)
                check($sformatf("v%0d_recv_b%0d", idx, i), recv_q[i], data[i]);
        end
        if (!wr) check($sformatf("v%0d_send_drained", idx), 8'(send_q.size()), 8'h00);
        release_channel();
    endtask

    initial begin : main
        bit         sel;
        logic [7:0] st;

        //            addr   cmd    busy n  d0     d1     sel   init   end
        vecs[0] = '{8'h20, 8'h01, 1'b0, 0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[1] = '{8'h10, 8'h00, 1'b0, 0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00};
        vecs[2] = '{8'h10, 8'h01, 1'b0, 2, 8'hA5, 8'h5A, 1'b1, 8'h00, 8'h30};
        vecs[3] = '{8'h10, 8'h02, 1'b0, 2, 8'h11, 8'h22, 1'b1, 8'h00, 8'h30};
        vecs[4] = '{8'h10, 8'h03, 1'b1, 0, 8'h00, 8'h00, 1'b1, 8'h08, 8'h00};
        vecs[5] = '{8'h10, 8'h05, 1'b0, 1, 8'h3C, 8'h00, 1'b1, 8'h00, 8'h30};
        vecs[6] = '{8'h10, 8'h06, 1'b0, 1, 8'h7E, 8'h00, 1'b1, 8'h00, 8'h30};

        reset_n = 1'b0;
        a_bus_out = 8'h00;
        a_operational_out = 1'b0;
        a_address_out = 1'b0;
        a_hold_out = 1'b0;
        a_select_out = 1'b0;
        a_command_out = 1'b0;
        a_service_out = 1'b0;
        a_suppress_out = 1'b0;
        device_busy = 1'b0;
        end_transfer = 1'b0;
        repeat (3) tick();
        check("reset_bus_in", a_bus_in, 8'h00);
        check("reset_op_in", 8'(a_operational_in), 8'h00);
        check("reset_command", command, 8'h00);
        check("reset_active", 8'(active), 8'h00);
        check("reset_request_in", 8'(a_request_in), 8'h00);
        reset_n = 1'b1;
        a_operational_out = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Channel stop during the second read byte
        send_q.push_back({1'b0, 8'h33});
        send_q.push_back({1'b0, 8'h44});
        send_q.push_back({1'b0, 8'h55});
        select_unit(ADDR, 8'h02, 1'b0, sel, st);
        check("stop_init_status", st, 8'h00);
        wait_sig(SIG_SVC, 1'b1, "stop_svc1");
        check("stop_byte1", a_bus_in, 8'h33);
        a_service_out = 1'b1;
        wait_sig(SIG_SVC, 1'b0, "stop_svc1_drop");
        a_service_out = 1'b0;
        wait_sig(SIG_SVC, 1'b1, "stop_svc2");
        a_command_out = 1'b1;
        wait_sig(SIG_SVC, 1'b0, "stop_svc2_drop");
        check("stop_bus_cleared", a_bus_in, 8'h00);
        check("stop_no_status_yet", 8'(a_status_in), 8'h00);
        a_command_out = 1'b0;
        wait_sig(SIG_STAT, 1'b1, "stop_end_status");
        check("stop_end_status", a_bus_in, 8'h30);
        a_service_out = 1'b1;
        wait_sig(SIG_STAT, 1'b0, "stop_end_ack");
        a_service_out = 1'b0;
        wait_sig(SIG_OP, 1'b0, "stop_op_drop");
        check("stop_remaining_stream", 8'(send_q.size()), 8'h01);
        send_q.delete();
        release_channel();

        // Selective reset (operational_out low) mid-read
        send_q.push_back({1'b0, 8'h77});
        select_unit(ADDR, 8'h02, 1'b0, sel, st);
        wait_sig(SIG_SVC, 1'b1, "selrst_svc");
        a_operational_out = 1'b0;
        tick();
        check("selrst_svc_in", 8'(a_service_in), 8'h00);
        check("selrst_op_in", 8'(a_operational_in), 8'h00);
        check("selrst_bus_in", a_bus_in, 8'h00);
        check("selrst_active", 8'(active), 8'h00);
        a_operational_out = 1'b1;
        send_q.delete();
        release_channel();

        // Asynchronous reset mid-write
        select_unit(ADDR, 8'h01, 1'b0, sel, st);
        wait_sig(SIG_SVC, 1'b1, "rst_svc");
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_svc_in", 8'(a_service_in), 8'h00);
        check("arst_op_in", 8'(a_operational_in), 8'h00);
        check("arst_active", 8'(active), 8'h00);
        check("arst_command", command, 8'h00);
        tick();
        reset_n = 1'b1;
        release_channel();
        check("arst_idle_op_in", 8'(a_operational_in), 8'h00);

        // Unit still works after reset
        run_vec(vecs[1], 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
